// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_flags block: read-mode encodings and pointer sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_fifo_pkg;

  // Read-mode selector values for the FWFT parameter
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Address width needed to index a storage array of 'depth' entries
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller guarantees the write address is free.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost_full/almost_empty, overflow/underflow pulses, STD or FWFT read.
// Latency: STD read data 1 cycle after rd_en; FWFT head word visible 1 cycle after its write.
// Backpressure: writes while full / reads while empty are dropped and flagged with a 1-cycle pulse.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ptr_width(DEPTH):0]  count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_SIZE = ptr_width(DEPTH);
  localparam int CW       = PTR_SIZE + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Elaboration-time parameter sanity checks
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("sync_fifo_flags: FWFT must be 0 or 1");
    end
  endgenerate

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags derive purely from the pointers; the extra MSB separates full from empty
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance uses start-of-cycle flags, so a slot freed this cycle is not reused until next
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PTR_SIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_ptr_q[PTR_SIZE-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[PTR_SIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  // Next-state: pointer advance, STD output register and error pulses
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = wr_en && full;
    unf_d    = rd_en && empty;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
      data_d   = mem_rdata;
      valid_d  = 1'b1;
    end
  end

  // State registers; reset wins over any same-cycle read or write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // FWFT presents the head word combinationally; STD presents the registered copy
  assign data_out  = (FWFT == FIFO_MODE_FWFT) ? mem_rdata : data_q;
  assign valid     = (FWFT == FIFO_MODE_FWFT) ? !empty    : valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one STD instance and one FWFT instance, DEPTH=8, AF=6, AE=2.
// Inputs are driven on the falling edge and outputs sampled on the next falling edge.
// Expected read data comes from per-instance queues filled as writes are driven.
module tb_sync_fifo_flags;

  logic clk;
  int   checks;
  int   errors;

  logic        a_rst, a_wr, a_rd;
  logic [15:0] a_din, a_dout;
  logic        a_vld, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0]  a_cnt;

  logic        b_rst, b_wr, b_rd;
  logic [15:0] b_din, b_dout;
  logic        b_vld, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0]  b_cnt;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  sync_fifo_flags #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(a_rst), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
    .data_out(a_dout), .valid(a_vld), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_flags #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(b_rst), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
    .data_out(b_dout), .valid(b_vld), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0;
    step();
    checks++;
    if ({a_empty, a_ae, a_full, a_af, a_vld, a_ovf, a_unf} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_flags: got e/ae/f/af/v/o/u=%b expected 1100000",
               {a_empty, a_ae, a_full, a_af, a_vld, a_ovf, a_unf});
    end
    checks++;
    if (a_cnt !== 4'd0 || a_dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_count_data: got count=%0d data=%h expected 0/0000", a_cnt, a_dout);
    end
    checks++;
    if (b_empty !== 1'b1 || b_vld !== 1'b0 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_fwft: got empty=%b valid=%b count=%0d expected 1/0/0", b_empty, b_vld, b_cnt);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      a_wr = 1'b1; a_din = 16'(i);
      qa.push_back(16'(i));
      step();
      checks++;
      if (a_cnt !== 4'(i) || a_full !== (i == 8) || a_af !== (i >= 6) || a_ae !== (i <= 2)) begin
        errors++;
        $display("FAIL fill_%0d: got count=%0d full=%b af=%b ae=%b expected %0d/%b/%b/%b",
                 i, a_cnt, a_full, a_af, a_ae, i, (i == 8), (i >= 6), (i <= 2));
      end
    end
    a_din = 16'hDEAD;
    step();
    a_wr = 1'b0;
    checks++;
    if (a_ovf !== 1'b1 || a_cnt !== 4'd8 || a_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got ovf=%b count=%0d full=%b expected 1/8/1", a_ovf, a_cnt, a_full);
    end
    step();
    checks++;
    if (a_ovf !== 1'b0 || a_cnt !== 4'd8) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%b count=%0d expected 0/8", a_ovf, a_cnt);
    end
  endtask

  task automatic test_drain();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      a_rd = 1'b1;
      exp = (qa.size() > 0) ? qa.pop_front() : 16'hXXXX;
      step();
      checks++;
      if (a_vld !== 1'b1 || a_dout !== exp || a_cnt !== 4'(7 - i)) begin
        errors++;
        $display("FAIL drain_%0d: got valid=%b data=%h count=%0d expected 1/%h/%0d",
                 i, a_vld, a_dout, a_cnt, exp, 7 - i);
      end
    end
    a_rd = 1'b0;
    step();
    checks++;
    if (a_vld !== 1'b0 || a_dout !== 16'h0008 || a_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle: got valid=%b data=%h empty=%b expected 0/0008/1", a_vld, a_dout, a_empty);
    end
    a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    checks++;
    if (a_unf !== 1'b1 || a_vld !== 1'b0 || a_cnt !== 4'd0) begin
      errors++;
      $display("FAIL underflow: got unf=%b valid=%b count=%0d expected 1/0/0", a_unf, a_vld, a_cnt);
    end
    step();
    checks++;
    if (a_unf !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got unf=%b expected 0", a_unf);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] d, exp;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) begin
        d = 16'($urandom);
        a_wr = 1'b1; a_din = d;
        qa.push_back(d);
        step();
      end
      a_wr = 1'b0;
      checks++;
      if (a_cnt !== 4'd5 || a_full !== 1'b0 || a_empty !== 1'b0) begin
        errors++;
        $display("FAIL wrap_fill_r%0d: got count=%0d full=%b empty=%b expected 5/0/0", r, a_cnt, a_full, a_empty);
      end
      for (int i = 0; i < 5; i++) begin
        a_rd = 1'b1;
        exp = (qa.size() > 0) ? qa.pop_front() : 16'hXXXX;
        step();
        checks++;
        if (a_vld !== 1'b1 || a_dout !== exp) begin
          errors++;
          $display("FAIL wrap_data_r%0d_%0d: got valid=%b data=%h expected 1/%h", r, i, a_vld, a_dout, exp);
        end
      end
      a_rd = 1'b0;
      checks++;
      if (a_empty !== 1'b1 || a_full !== 1'b0 || a_cnt !== 4'd0) begin
        errors++;
        $display("FAIL wrap_empty_r%0d: got empty=%b full=%b count=%0d expected 1/0/0", r, a_empty, a_full, a_cnt);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      a_wr = 1'b1; a_din = 16'h0100 + 16'(i);
      qa.push_back(a_din);
      step();
    end
    a_wr = 1'b1; a_rd = 1'b1; a_din = 16'h0200;
    qa.push_back(16'h0200);
    exp = qa.pop_front();
    step();
    a_rd = 1'b0;
    checks++;
    if (a_cnt !== 4'd3 || a_vld !== 1'b1 || a_dout !== exp) begin
      errors++;
      $display("FAIL simul_mid: got count=%0d valid=%b data=%h expected 3/1/%h", a_cnt, a_vld, a_dout, exp);
    end
    for (int i = 0; i < 5; i++) begin
      a_din = 16'h0300 + 16'(i);
      qa.push_back(a_din);
      step();
    end
    a_din = 16'hDEAD; a_rd = 1'b1;
    exp = qa.pop_front();
    step();
    a_wr = 1'b0; a_rd = 1'b0;
    checks++;
    if (a_cnt !== 4'd7 || a_ovf !== 1'b1 || a_vld !== 1'b1 || a_dout !== exp) begin
      errors++;
      $display("FAIL simul_full: got count=%0d ovf=%b valid=%b data=%h expected 7/1/1/%h",
               a_cnt, a_ovf, a_vld, a_dout, exp);
    end
    for (int i = 0; i < 7; i++) begin
      a_rd = 1'b1;
      exp = (qa.size() > 0) ? qa.pop_front() : 16'hXXXX;
      step();
      checks++;
      if (a_dout !== exp) begin
        errors++;
        $display("FAIL simul_drain_%0d: got data=%h expected %h", i, a_dout, exp);
      end
    end
    a_wr = 1'b1; a_rd = 1'b1; a_din = 16'h1234;
    step();
    a_wr = 1'b0; a_rd = 1'b0;
    checks++;
    if (a_cnt !== 4'd1 || a_unf !== 1'b1 || a_vld !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: got count=%0d unf=%b valid=%b expected 1/1/0", a_cnt, a_unf, a_vld);
    end
    a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    checks++;
    if (a_dout !== 16'h1234 || a_vld !== 1'b1 || a_cnt !== 4'd0) begin
      errors++;
      $display("FAIL simul_empty_read: got data=%h valid=%b count=%0d expected 1234/1/0", a_dout, a_vld, a_cnt);
    end
  endtask

  task automatic test_fwft();
    b_wr = 1'b1; b_din = 16'h00AA;
    step();
    b_wr = 1'b0;
    checks++;
    if (b_vld !== 1'b1 || b_dout !== 16'h00AA || b_cnt !== 4'd1) begin
      errors++;
      $display("FAIL fwft_head: got valid=%b data=%h count=%0d expected 1/00aa/1", b_vld, b_dout, b_cnt);
    end
    b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    checks++;
    if (b_vld !== 1'b0 || b_empty !== 1'b1) begin
      errors++;
      $display("FAIL fwft_pop: got valid=%b empty=%b expected 0/1", b_vld, b_empty);
    end
    for (int i = 0; i < 3; i++) begin
      b_wr = 1'b1; b_din = 16'h0B00 + 16'(i);
      qb.push_back(b_din);
      step();
    end
    b_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b_vld !== 1'b1 || b_dout !== qb[0]) begin
        errors++;
        $display("FAIL fwft_stream_%0d: got valid=%b data=%h expected 1/%h", i, b_vld, b_dout, qb[0]);
      end
      void'(qb.pop_front());
      b_rd = 1'b1;
      step();
      b_rd = 1'b0;
    end
    checks++;
    if (b_vld !== 1'b0 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL fwft_stream_end: got valid=%b count=%0d expected 0/0", b_vld, b_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      b_wr = 1'b1; b_din = 16'h0C00 + 16'(i);
      step();
    end
    checks++;
    if (b_cnt !== 4'd5) begin
      errors++;
      $display("FAIL rst_mid_pre: got count=%0d expected 5", b_cnt);
    end
    b_rst = 1'b1; b_din = 16'h5555;
    step();
    b_rst = 1'b0; b_wr = 1'b0;
    checks++;
    if (b_cnt !== 4'd0 || b_empty !== 1'b1 || b_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got count=%0d empty=%b valid=%b expected 0/1/0", b_cnt, b_empty, b_vld);
    end
    step();
    checks++;
    if (b_cnt !== 4'd0 || b_ovf !== 1'b0 || b_unf !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold: got count=%0d ovf=%b unf=%b expected 0/0/0", b_cnt, b_ovf, b_unf);
    end
    b_wr = 1'b1; b_din = 16'h0077;
    step();
    b_wr = 1'b0;
    checks++;
    if (b_vld !== 1'b1 || b_dout !== 16'h0077 || b_cnt !== 4'd1) begin
      errors++;
      $display("FAIL rst_mid_restart: got valid=%b data=%h count=%0d expected 1/0077/1", b_vld, b_dout, b_cnt);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
